// File: rtl/reaction_pkg.sv
// Shared state encoding and BCD constants for the reaction-timer game.
package reaction_pkg;
   typedef enum logic [1:0] {A = 2'd0, B = 2'd1, C = 2'd2, D = 2'd3} state_t;

   localparam logic [3:0]  BCD_NINE = 4'd9;
   localparam logic [15:0] HS_RESET = {4{BCD_NINE}};
endpackage

// File: rtl/lfsr_rand.sv
// Free-running Fibonacci LFSR, seed 1; feedback from bits W-1 and W-3 gives x^W+x^(W-2)+1.
module lfsr_rand #(
   parameter int W = 11
) (
   input  logic         Clk,
   input  logic         Resetn,
   output logic [W-1:0] q
);
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) q <= W'(1);
      else         q <= {q[W-2:0], q[W-1] ^ q[W-3]};
   end
endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-game sequencer: random pre-GO delay, counter gating/clear, best-time tracking.
module reaction_game_ctrl
   import reaction_pkg::*;
#(
   parameter int MIN_DELAY_MS = 1000,
   parameter int RAND_W       = 11,
   parameter int DLY_W        = 12
) (
   input  logic       Clk,
   input  logic       Resetn,
   input  logic       ms_tick,
   input  logic       Start,
   input  logic       Stop,
   input  logic       HS_clear,
   input  logic [3:0] S,
   input  logic [3:0] tS,
   input  logic [3:0] hS,
   input  logic [3:0] mS,
   output logic [1:0] state,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       go_led,
   output logic       false_start,
   output logic       timeout,
   output logic       new_record,
   output logic [3:0] h_S,
   output logic [3:0] h_tS,
   output logic [3:0] h_hS,
   output logic [3:0] h_mS
);
   state_t            st, st_n;
   logic [DLY_W-1:0]  dly, dly_n;
   logic [15:0]       hs, hs_n;
   logic [15:0]       live;
   logic [RAND_W-1:0] rnd;
   logic              at_max, start_round;
   logic              clr_n, go_n, fs_n, to_n, nr_n;

   lfsr_rand #(.W(RAND_W)) u_lfsr (.Clk(Clk), .Resetn(Resetn), .q(rnd));

   // Packed BCD compares correctly as a plain unsigned number.
   assign live        = {S, tS, hS, mS};
   assign at_max      = (live == HS_RESET);
   assign cnt_en      = (st == C) & ms_tick & ~Stop & ~at_max;
   assign start_round = Start & ((st == A) | (st == D));
   assign state       = st;
   assign {h_S, h_tS, h_hS, h_mS} = hs;

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         st          <= A;
         dly         <= '0;
         hs          <= HS_RESET;
         cnt_clr     <= 1'b0;
         go_led      <= 1'b0;
         false_start <= 1'b0;
         timeout     <= 1'b0;
         new_record  <= 1'b0;
      end else begin
         st          <= st_n;
         dly         <= dly_n;
         hs          <= hs_n;
         cnt_clr     <= clr_n;
         go_led      <= go_n;
         false_start <= fs_n;
         timeout     <= to_n;
         new_record  <= nr_n;
      end
   end

   always_comb begin
      st_n  = st;
      dly_n = dly;
      hs_n  = hs;
      clr_n = 1'b0;
      go_n  = go_led;
      fs_n  = false_start;
      to_n  = timeout;
      nr_n  = new_record;
      unique case (st)
         A: if (HS_clear) hs_n = HS_RESET;
         B: begin
            if (Stop) begin
               st_n = D;
               fs_n = 1'b1;
            end else if (ms_tick) begin
               if (dly == DLY_W'(1)) begin
                  st_n = C;
                  go_n = 1'b1;
               end else begin
                  dly_n = dly - DLY_W'(1);
               end
            end
         end
         C: begin
            if (Stop) begin
               st_n = D;
               go_n = 1'b0;
               if (live < hs) begin
                  hs_n = live;
                  nr_n = 1'b1;
               end
            end else if (ms_tick && at_max) begin
               st_n = D;
               go_n = 1'b0;
               to_n = 1'b1;
            end
         end
         D: begin
            go_n = 1'b0;
            if (Stop) st_n = A;
         end
      endcase
      // Start out of A or D overrides Stop in D and starts a fresh round.
      if (start_round) begin
         st_n  = B;
         clr_n = 1'b1;
         fs_n  = 1'b0;
         to_n  = 1'b0;
         nr_n  = 1'b0;
         dly_n = DLY_W'(MIN_DELAY_MS) + DLY_W'(rnd);
      end
   end
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench: external BCD counter model, round-level reference (running best time, LFSR-derived delay).
module tb_reaction_game_ctrl;
   localparam int MIN    = 1000;
   localparam int K_STOP = 0;
   localparam int K_FS   = 1;
   localparam int K_TO   = 2;

   typedef struct {
      int kind;
      int target;
      bit hsc_c;
      int exp_hs;
      bit exp_nr;
      bit exp_fs;
      bit exp_to;
   } rnd_t;

   logic       Clk = 1'b0, Resetn = 1'b0, ms_tick = 1'b0;
   logic       Start = 1'b0, Stop = 1'b0, HS_clear = 1'b0;
   logic [3:0] S, tS, hS, mS;
   logic [1:0] state;
   logic       cnt_en, cnt_clr, go_led, false_start, timeout, new_record;
   logic [3:0] h_S, h_tS, h_hS, h_mS;
   logic [10:0] ref_lfsr;
   int         cnt = 0;
   int         checks = 0, errors = 0;

   reaction_game_ctrl dut (
      .Clk(Clk), .Resetn(Resetn), .ms_tick(ms_tick), .Start(Start), .Stop(Stop),
      .HS_clear(HS_clear), .S(S), .tS(tS), .hS(hS), .mS(mS), .state(state),
      .cnt_en(cnt_en), .cnt_clr(cnt_clr), .go_led(go_led), .false_start(false_start),
      .timeout(timeout), .new_record(new_record),
      .h_S(h_S), .h_tS(h_tS), .h_hS(h_hS), .h_mS(h_mS)
   );

   always #5 Clk = ~Clk;

   // External 4-digit BCD ms counter, held as an integer 0..9999.
   always @(posedge Clk) begin
      if (cnt_clr)     cnt <= 0;
      else if (cnt_en) cnt <= cnt + 1;
   end
   always_comb begin
      S  = 4'(cnt / 1000);
      tS = 4'((cnt / 100) % 10);
      hS = 4'((cnt / 10) % 10);
      mS = 4'(cnt % 10);
   end

   // Expected random source: x^11+x^9+1 from seed 1, one step per clock.
   always @(posedge Clk or negedge Resetn) begin
      if (!Resetn) ref_lfsr <= 11'd1;
      else         ref_lfsr <= 11'(((ref_lfsr << 1) & 11'h7ff) | 11'(((ref_lfsr >> 10) ^ (ref_lfsr >> 8)) & 11'd1));
   end

   function automatic int hs_val();
      return int'(h_S) * 1000 + int'(h_tS) * 100 + int'(h_hS) * 10 + int'(h_mS);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Inputs are set at the negedge; settle, check combinational rules, move to next negedge.
   task automatic cyc();
      #1;
      chk("cnt_en_rule", 32'(cnt_en), 32'((state == 2'd2) && ms_tick && !Stop && (cnt != 9999)));
      chk("go_led_in_C", 32'(go_led), 32'(state == 2'd2));
      @(negedge Clk);
   endtask

   task automatic run_round(input int kind, input int target, input bit rnd_tick, input bit hsc_c,
                            output int b_ticks, output int clrs, output int gos, output int dly_exp);
      int guard;
      bit first_c;
      b_ticks = 0; clrs = 0; gos = 0; guard = 0; first_c = 1'b1;
      dly_exp = MIN + int'(ref_lfsr);
      Start = 1'b1; ms_tick = 1'b1;
      cyc();
      Start = 1'b0;
      while (state == 2'd1 && guard < 4000) begin
         guard++;
         if (cnt_clr) clrs++;
         if (go_led)  gos++;
         ms_tick = rnd_tick ? ($urandom_range(0, 7) != 0) : 1'b1;
         Stop    = (kind == K_FS) && (guard == target);
         if (ms_tick) b_ticks++;
         cyc();
      end
      Stop = 1'b0;
      while (state == 2'd2 && guard < 16000) begin
         guard++;
         if (cnt_clr) clrs++;
         if (go_led)  gos++;
         ms_tick  = rnd_tick ? ($urandom_range(0, 7) != 0) : 1'b1;
         Stop     = (kind == K_STOP) && (cnt == target);
         HS_clear = hsc_c && first_c;
         first_c  = 1'b0;
         cyc();
      end
      Stop = 1'b0; HS_clear = 1'b0; ms_tick = 1'b1;
   endtask

   task automatic check_round(input int kind, input int target, input int exp_hs, input bit exp_nr,
                              input bit exp_fs, input bit exp_to,
                              input int bt, input int cl, input int gs, input int de);
      chk("round_end_state", 32'(state), 32'd3);
      chk("false_start", 32'(false_start), 32'(exp_fs));
      chk("timeout", 32'(timeout), 32'(exp_to));
      chk("new_record", 32'(new_record), 32'(exp_nr));
      chk("high_score", hs_val(), exp_hs);
      chk("cnt_clr_once", cl, 1);
      chk("go_seen", 32'(gs > 0), 32'(kind != K_FS));
      chk("final_count", cnt, (kind == K_STOP) ? target : (kind == K_TO) ? 9999 : 0);
      if (kind != K_FS) begin
         chk("b_delay", bt, de);
         chk("b_delay_range", 32'(bt >= 1000 && bt <= 3047), 32'd1);
      end
   endtask

   initial begin
      rnd_t tbl [6];
      int   bt, cl, gs, de, kind, target, ref_hs, g;
      bit   exp_nr, in_a;

      tbl[0] = '{K_STOP, 250, 1'b0, 250, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{K_STOP, 300, 1'b1, 250, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{K_STOP, 250, 1'b0, 250, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{K_FS,   500, 1'b0, 250, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{K_TO,     0, 1'b0, 250, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{K_STOP, 249, 1'b0, 249, 1'b1, 1'b0, 1'b0};

      #12;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cnt_clr", 32'(cnt_clr), 32'd0);
      chk("rst_go_led", 32'(go_led), 32'd0);
      chk("rst_flags", 32'({false_start, timeout, new_record}), 32'd0);
      chk("rst_high_score", hs_val(), 9999);
      @(negedge Clk); Resetn = 1'b1;
      @(negedge Clk);

      for (int i = 0; i < 6; i++) begin
         run_round(tbl[i].kind, tbl[i].target, 1'b0, tbl[i].hsc_c, bt, cl, gs, de);
         check_round(tbl[i].kind, tbl[i].target, tbl[i].exp_hs, tbl[i].exp_nr,
                     tbl[i].exp_fs, tbl[i].exp_to, bt, cl, gs, de);
         if (i == 0) begin
            Stop = 1'b1; cyc(); Stop = 1'b0;
            chk("stop_D_to_A", 32'(state), 32'd0);
            chk("hs_digits_in_A", 32'({h_S, h_tS, h_hS, h_mS}), 32'h0250);
         end
         if (i == 4) begin
            cyc();
            chk("timeout_hold_en", 32'(cnt_en), 32'd0);
            chk("timeout_hold_cnt", cnt, 9999);
         end
      end

      // Start and Stop together in D: Start wins.
      Start = 1'b1; Stop = 1'b1; cyc(); Start = 1'b0; Stop = 1'b0;
      chk("start_stop_D", 32'(state), 32'd1);
      chk("clr_on_entry", 32'(cnt_clr), 32'd1);
      Stop = 1'b1; cyc(); Stop = 1'b0;
      chk("fs_state", 32'(state), 32'd3);
      chk("fs_flag", 32'(false_start), 32'd1);
      Stop = 1'b1; cyc(); Stop = 1'b0;
      chk("to_A", 32'(state), 32'd0);
      HS_clear = 1'b1; cyc(); HS_clear = 1'b0;
      chk("hs_clear_A", hs_val(), 9999);
      run_round(K_STOP, 200, 1'b0, 1'b0, bt, cl, gs, de);
      check_round(K_STOP, 200, 200, 1'b1, 1'b0, 1'b0, bt, cl, gs, de);
      Stop = 1'b1; cyc(); Stop = 1'b0;
      Start = 1'b1; HS_clear = 1'b1; cyc(); Start = 1'b0; HS_clear = 1'b0;
      chk("start_hsclr_state", 32'(state), 32'd1);
      chk("start_hsclr_hs", hs_val(), 9999);
      Stop = 1'b1; cyc(); Stop = 1'b0;
      run_round(K_STOP, 150, 1'b0, 1'b0, bt, cl, gs, de);
      check_round(K_STOP, 150, 150, 1'b1, 1'b0, 1'b0, bt, cl, gs, de);

      // Reset asserted in the middle of C.
      Start = 1'b1; cyc(); Start = 1'b0;
      g = 0;
      while (state != 2'd2 && g < 4000) begin g++; cyc(); end
      chk("reach_C", 32'(state), 32'd2);
      repeat (5) cyc();
      #2 Resetn = 1'b0;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_go", 32'(go_led), 32'd0);
      chk("async_rst_hs", hs_val(), 9999);
      @(negedge Clk); Resetn = 1'b1;
      @(negedge Clk);

      ref_hs = 9999;
      in_a   = 1'b1;
      for (int r = 0; r < 10; r++) begin
         if (!in_a && $urandom_range(0, 3) == 0) begin
            Stop = 1'b1; cyc(); Stop = 1'b0;
            chk("rnd_to_A", 32'(state), 32'd0);
            in_a = 1'b1;
         end
         if (in_a && $urandom_range(0, 1) == 1) begin
            HS_clear = 1'b1; cyc(); HS_clear = 1'b0;
            ref_hs = 9999;
         end
         kind   = ($urandom_range(0, 4) == 0) ? K_FS : K_STOP;
         target = (kind == K_FS) ? int'($urandom_range(1, 900)) : int'($urandom_range(0, 800));
         exp_nr = (kind == K_STOP) && (target < ref_hs);
         if (exp_nr) ref_hs = target;
         run_round(kind, target, 1'b1, 1'b0, bt, cl, gs, de);
         check_round(kind, target, ref_hs, exp_nr, kind == K_FS, 1'b0, bt, cl, gs, de);
         in_a = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
